// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scan driver: one shared one-hot digit select feeds two segment blocks.
// It renders per-frame snapshots of the inputs, with leading-zero blanking, blink, decimal points and an enable.
module scan_display_ctrl #(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned BLINK_HALF = 250,
    parameter int unsigned HEX_EN     = 0
) (
    input  logic                    clk_1khz,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   dig_r,
    input  logic [4*N_DIGITS-1:0]   dig_l,
    input  logic [N_DIGITS-1:0]     dp_r,
    input  logic [N_DIGITS-1:0]     dp_l,
    input  logic                    lz_l,
    input  logic [N_DIGITS-1:0]     blink_r,
    input  logic [N_DIGITS-1:0]     blink_l,
    output logic [N_DIGITS-1:0]     wei,
    output logic [7:0]              duan,
    output logic [7:0]              duan1
);

    localparam int unsigned SCAN_W  = $clog2(N_DIGITS);
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned DIG_W   = 4 * N_DIGITS;
    localparam logic [SCAN_W-1:0]  LAST_POS   = SCAN_W'(N_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_blink_ph;
    logic [DIG_W-1:0]    r_dig_r;
    logic [DIG_W-1:0]    r_dig_l;
    logic [N_DIGITS-1:0] r_dp_r;
    logic [N_DIGITS-1:0] r_dp_l;
    logic                r_lz_l;
    logic [N_DIGITS-1:0] r_blink_r;
    logic [N_DIGITS-1:0] r_blink_l;
    logic [N_DIGITS-1:0] r_wei;
    logic [7:0]          r_duan;
    logic [7:0]          r_duan1;

    logic [3:0]          w_code_r;
    logic [3:0]          w_code_l;
    logic                w_dp_r;
    logic                w_dp_l;
    logic                w_blink_r;
    logic                w_blink_l;
    logic                w_lz_blank;
    logic                w_zero_run;
    logic [N_DIGITS-1:0] w_wei_nxt;
    logic [7:0]          w_glyph_r;
    logic [7:0]          w_glyph_l;

    // Segment pattern {a,b,c,d,e,f,g,dp} for one code; dp bit is always clear here
    function automatic logic [7:0] f_glyph(input logic [3:0] i_code);
        logic [7:0] v;
        v = 8'h00;
        case (i_code)
            4'h0: v = 8'hFC;
            4'h1: v = 8'h60;
            4'h2: v = 8'hDA;
            4'h3: v = 8'hF2;
            4'h4: v = 8'h66;
            4'h5: v = 8'hB6;
            4'h6: v = 8'hBE;
            4'h7: v = 8'hE0;
            4'h8: v = 8'hFE;
            4'h9: v = 8'hF6;
            4'hA: v = (HEX_EN != 0) ? 8'hEE : 8'h00;
            4'hB: v = (HEX_EN != 0) ? 8'h3E : 8'h00;
            4'hC: v = (HEX_EN != 0) ? 8'h9C : 8'h00;
            4'hD: v = (HEX_EN != 0) ? 8'h7A : 8'h00;
            4'hE: v = (HEX_EN != 0) ? 8'h9E : 8'h00;
            default: v = (HEX_EN != 0) ? 8'h8E : 8'h00;
        endcase
        return v;
    endfunction

    // Select the shadow fields of the current position; the zero run grows from the leftmost digit
    always_comb begin
        w_code_r   = 4'h0;
        w_code_l   = 4'h0;
        w_dp_r     = 1'b0;
        w_dp_l     = 1'b0;
        w_blink_r  = 1'b0;
        w_blink_l  = 1'b0;
        w_lz_blank = 1'b0;
        w_wei_nxt  = '0;
        w_zero_run = 1'b1;
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run & (r_dig_l[4*k +: 4] == 4'h0);
            if (r_scan_cnt == SCAN_W'(k)) begin
                w_code_r     = r_dig_r[4*k +: 4];
                w_code_l     = r_dig_l[4*k +: 4];
                w_dp_r       = r_dp_r[k];
                w_dp_l       = r_dp_l[k];
                w_blink_r    = r_blink_r[k];
                w_blink_l    = r_blink_l[k];
                w_lz_blank   = r_lz_l & w_zero_run & (k != 0);
                w_wei_nxt[k] = 1'b1;
            end
        end
    end

    // Blink beats leading-zero blanking, and both also kill the decimal point
    always_comb begin
        w_glyph_r = f_glyph(w_code_r) | {7'b0, w_dp_r};
        w_glyph_l = f_glyph(w_code_l) | {7'b0, w_dp_l};
        if (w_blink_r & r_blink_ph) begin
            w_glyph_r = 8'h00;
        end
        if ((w_blink_l & r_blink_ph) | w_lz_blank) begin
            w_glyph_l = 8'h00;
        end
    end

    // Scan and blink timebases run regardless of en
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else begin
            r_scan_cnt <= (r_scan_cnt == LAST_POS) ? '0 : r_scan_cnt + SCAN_W'(1);
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Shadow copy taken on the last position so a frame never tears
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            r_dig_r   <= '0;
            r_dig_l   <= '0;
            r_dp_r    <= '0;
            r_dp_l    <= '0;
            r_lz_l    <= 1'b0;
            r_blink_r <= '0;
            r_blink_l <= '0;
        end else if (r_scan_cnt == LAST_POS) begin
            r_dig_r   <= dig_r;
            r_dig_l   <= dig_l;
            r_dp_r    <= dp_r;
            r_dp_l    <= dp_l;
            r_lz_l    <= lz_l;
            r_blink_r <= blink_r;
            r_blink_l <= blink_l;
        end
    end

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            r_wei   <= '0;
            r_duan  <= 8'h00;
            r_duan1 <= 8'h00;
        end else begin
            r_wei   <= en ? w_wei_nxt : '0;
            r_duan  <= en ? w_glyph_r : 8'h00;
            r_duan1 <= en ? w_glyph_l : 8'h00;
        end
    end

    assign wei   = r_wei;
    assign duan  = r_duan;
    assign duan1 = r_duan1;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: a hex-enabled and a hex-disabled instance share the same stimulus.
// Expected frames come from hand-derived tables and a queue scoreboard.
module tb_scan_display_ctrl;

    localparam int unsigned N = 4;

    logic            clk_1khz = 1'b0;
    logic            rst;
    logic            en;
    logic [4*N-1:0]  dig_r, dig_l;
    logic [N-1:0]    dp_r, dp_l, blink_r, blink_l;
    logic            lz_l;
    logic [N-1:0]    wei, wei0;
    logic [7:0]      duan, duan1, duan0, duan1_0;

    scan_display_ctrl #(.N_DIGITS(N), .BLINK_HALF(4), .HEX_EN(1)) u_dut (
        .clk_1khz(clk_1khz), .rst(rst), .en(en), .dig_r(dig_r), .dig_l(dig_l),
        .dp_r(dp_r), .dp_l(dp_l), .lz_l(lz_l), .blink_r(blink_r), .blink_l(blink_l),
        .wei(wei), .duan(duan), .duan1(duan1)
    );

    scan_display_ctrl #(.N_DIGITS(N), .BLINK_HALF(4), .HEX_EN(0)) u_dut0 (
        .clk_1khz(clk_1khz), .rst(rst), .en(en), .dig_r(dig_r), .dig_l(dig_l),
        .dp_r(dp_r), .dp_l(dp_l), .lz_l(lz_l), .blink_r(blink_r), .blink_l(blink_l),
        .wei(wei0), .duan(duan0), .duan1(duan1_0)
    );

    always #5 clk_1khz = ~clk_1khz;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  wei;
        logic [7:0]  duan;
        logic [7:0]  duan1;
        logic [7:0]  duan0;
    } exp_t;

    typedef struct {
        logic [15:0]     dig_l;
        logic [15:0]     dig_r;
        logic [3:0]      dp_l;
        logic [3:0]      dp_r;
        logic            lz;
        logic [3:0][7:0] el;
        logic [3:0][7:0] er;
        logic [3:0][7:0] er0;
    } vec_t;

    exp_t    sb_q[$];
    exp_t    sb_e;
    vec_t    vecs[7];
    int      errors = 0;
    int      checks = 0;
    int      sc = 0;
    int      fr = 0;
    int      next_id = 0;

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (wei,duan,duan1,wei0,duan0,duan1_0)", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {24'h0, wei, duan, duan1, wei0, duan0, duan1_0};
    endfunction

    always @(negedge clk_1khz) begin
        if (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            cmp($sformatf("sb#%0d", sb_e.id), outs(),
                {24'h0, sb_e.wei, sb_e.duan, sb_e.duan1, sb_e.wei, sb_e.duan0, sb_e.duan1});
        end
    end

    function automatic exp_t mk(input int p, input logic [7:0] r, input logic [7:0] l, input logic [7:0] r0);
        exp_t e;
        e.id    = 16'h0;
        e.wei   = 4'(1 << p);
        e.duan  = r;
        e.duan1 = l;
        e.duan0 = r0;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [15:0] dl, input logic [15:0] dr, input logic [3:0] pl,
                                 input logic [3:0] pr, input logic z, input logic [31:0] el,
                                 input logic [31:0] er, input logic [31:0] er0);
        vec_t v;
        v.dig_l = dl; v.dig_r = dr; v.dp_l = pl; v.dp_r = pr; v.lz = z;
        v.el = el; v.er = er; v.er0 = er0;
        return v;
    endfunction

    // Queue the expectation for the coming edge; sc tracks the position rendered at that edge
    task automatic tick(input bit chk, input exp_t e);
        @(posedge clk_1khz);
        if (chk) begin
            e.id = 16'(next_id);
            next_id++;
            sb_q.push_back(e);
        end
        #1;
        sc = (sc + 1) % 4;
        if (sc == 0) fr++;
    endtask

    task automatic align_last();
        while (sc != 3) tick(1'b0, '0);
    endtask

    task automatic run_vec(input vec_t v);
        align_last();
        dig_l = v.dig_l; dig_r = v.dig_r; dp_l = v.dp_l; dp_r = v.dp_r; lz_l = v.lz;
        tick(1'b0, '0);
        repeat (2) begin
            for (int p = 0; p < 4; p++) tick(1'b1, mk(p, v.er[p], v.el[p], v.er0[p]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; lz_l = 1'b0;
        dig_r = '0; dig_l = '0; dp_r = '0; dp_l = '0; blink_r = '0; blink_l = '0;

        // Tables list positions 3..0 from left to right
        vecs[0] = mkv(16'h1234, 16'h5678, 4'h0, 4'h0, 1'b0, {8'h60, 8'hDA, 8'hF2, 8'h66},
                      {8'hB6, 8'hBE, 8'hE0, 8'hFE}, {8'hB6, 8'hBE, 8'hE0, 8'hFE});
        vecs[1] = mkv(16'h0005, 16'h0000, 4'b1000, 4'h0, 1'b1, {8'h00, 8'h00, 8'h00, 8'hB6},
                      {8'hFC, 8'hFC, 8'hFC, 8'hFC}, {8'hFC, 8'hFC, 8'hFC, 8'hFC});
        vecs[2] = mkv(16'h0000, 16'h0000, 4'h0, 4'h0, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFC},
                      {8'hFC, 8'hFC, 8'hFC, 8'hFC}, {8'hFC, 8'hFC, 8'hFC, 8'hFC});
        vecs[3] = mkv(16'h0000, 16'h000A, 4'h0, 4'h0, 1'b0, {8'hFC, 8'hFC, 8'hFC, 8'hFC},
                      {8'hFC, 8'hFC, 8'hFC, 8'hEE}, {8'hFC, 8'hFC, 8'hFC, 8'h00});
        vecs[4] = mkv(16'h0000, 16'hF0CA, 4'h0, 4'b0100, 1'b0, {8'hFC, 8'hFC, 8'hFC, 8'hFC},
                      {8'h8E, 8'hFD, 8'h9C, 8'hEE}, {8'h00, 8'hFD, 8'h00, 8'h00});
        vecs[5] = mkv(16'h0305, 16'hBD49, 4'b1111, 4'h0, 1'b1, {8'h00, 8'hF3, 8'hFD, 8'hB7},
                      {8'h3E, 8'h7A, 8'h66, 8'hF6}, {8'h00, 8'h00, 8'h66, 8'hF6});
        vecs[6] = mkv(16'h0000, 16'h1234, 4'h0, 4'b1010, 1'b0, {8'hFC, 8'hFC, 8'hFC, 8'hFC},
                      {8'h61, 8'hDA, 8'hF3, 8'h66}, {8'h61, 8'hDA, 8'hF3, 8'h66});

        #3;
        cmp("reset_state", outs(), 64'h0);
        @(posedge clk_1khz); #1;
        rst = 1'b0; sc = 0; fr = 0;

        // Zeroed shadow in frame 0; inputs appear from frame 1
        dig_l = 16'h1234; dig_r = 16'h5678;
        for (int i = 0; i < 4; i++) tick(1'b1, mk(sc, 8'hFC, 8'hFC, 8'hFC));
        tick(1'b1, mk(sc, 8'hFE, 8'h66, 8'hFE));

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Asynchronous reset mid-frame, then a zeroed first frame despite live inputs
        while (sc != 1) tick(1'b0, '0);
        #2 rst = 1'b1;
        #1 cmp("rst_async", outs(), 64'h0);
        @(posedge clk_1khz); #1;
        cmp("rst_held", outs(), 64'h0);
        rst = 1'b0; sc = 0; fr = 0;
        for (int p = 0; p < 4; p++) tick(1'b1, mk(p, 8'hFC, 8'hFC, 8'hFC));
        for (int p = 0; p < 4; p++) tick(1'b1, mk(p, vecs[6].er[p], 8'hFC, vecs[6].er0[p]));

        // Blink phase flips every 4 ticks, i.e. once per frame since reset
        align_last();
        dig_r = '0; dig_l = '0; dp_r = 4'b0001; dp_l = '0; lz_l = 1'b0;
        blink_r = 4'b0001; blink_l = 4'b0100;
        tick(1'b0, '0);
        repeat (4) begin
            for (int p = 0; p < 4; p++) begin
                logic [7:0] r, l;
                r = (p == 0) ? (((fr % 2) == 1) ? 8'h00 : 8'hFD) : 8'hFC;
                l = (p == 2) ? (((fr % 2) == 1) ? 8'h00 : 8'hFC) : 8'hFC;
                tick(1'b1, mk(p, r, l, r));
            end
        end

        // Input change mid-frame stays hidden until the next frame
        align_last();
        dig_r = 16'h1111; dp_r = '0; blink_r = '0; blink_l = '0;
        tick(1'b0, '0);
        tick(1'b1, mk(0, 8'h60, 8'hFC, 8'h60));
        dig_r = 16'h2222;
        for (int p = 1; p < 4; p++) tick(1'b1, mk(p, 8'h60, 8'hFC, 8'h60));
        for (int p = 0; p < 4; p++) tick(1'b1, mk(p, 8'hDA, 8'hFC, 8'hDA));

        // Display disable blanks everything while the scan keeps moving
        en = 1'b0;
        repeat (3) tick(1'b1, '0);
        en = 1'b1;
        repeat (2) tick(1'b1, mk(sc, 8'hDA, 8'hFC, 8'hDA));

        @(negedge clk_1khz); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
